// File: rtl/localization_pkg.sv
// Shared widths, vector field layout, FSM state type and saturating add
// for the localization datapath.
package localization_pkg;

  localparam int VEC_W    = 16;
  localparam int MAG_W    = 16;
  localparam int ACC_W    = 32;
  localparam int MAG_FRAC = 13;
  localparam int WGT_W    = 20;
  localparam int CNT_W    = 11;

  localparam int VEC_IN_W = 38;
  localparam int X_LSB    = 0;
  localparam int Y_LSB    = 16;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } sat_sum_t;

  // Two's-complement add of a weighted sample onto an accumulator, clamped
  // to the signed ACC_W range; ovf flags that the clamp engaged.
  function automatic sat_sum_t sat_add(input logic [ACC_W-1:0] acc,
                                       input logic [WGT_W-1:0] w);
    logic [ACC_W:0] wide;
    sat_sum_t       res;
    wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-WGT_W){w[WGT_W-1]}}, w};
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      res.sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      res.ovf = 1'b1;
    end else begin
      res.sum = wide[ACC_W-1:0];
      res.ovf = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mag_weighter.sv
// One axis of the S2 stage: signed 6.10 component times unsigned 3.13
// magnitude, rescaled back to 6.10 and registered.
module mag_weighter
  import localization_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic signed [VEC_W-1:0] i_comp,
  input  logic        [MAG_W-1:0] i_mag,
  output logic signed [WGT_W-1:0] o_weighted
);

  logic signed [VEC_W+MAG_W:0] w_product;

  assign w_product = i_comp * $signed({1'b0, i_mag});

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) o_weighted <= '0;
    else           o_weighted <= WGT_W'(w_product >>> MAG_FRAC);
  end

endmodule

// File: rtl/direction_accumulator.sv
// Per-frame magnitude-weighted sum of direction vectors over a bin window,
// three-stage pipeline with a one-cycle result strobe.
module direction_accumulator
  import localization_pkg::*;
#(
  parameter int FRAME_BINS = 1024,
  parameter int BIN_LO     = 4,
  parameter int BIN_HI     = 127
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [VEC_IN_W-1:0] vector_in,
  input  logic [MAG_W-1:0]    mag_in,
  input  logic                valid_in,
  input  logic                last_in,
  input  logic [MAG_W-1:0]    mag_threshold_in,
  output logic [ACC_W-1:0]    x_out,
  output logic [ACC_W-1:0]    y_out,
  output logic [CNT_W-1:0]    count_out,
  output logic                valid_out,
  output logic                overflow_out
);

  localparam int              IDX_W   = (FRAME_BINS > 1) ? $clog2(FRAME_BINS) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FRAME_BINS - 1);

  acc_state_e              r_state;
  logic [IDX_W-1:0]        r_bin_idx;
  logic [31:0]             w_idx_ext;
  logic                    w_beat_last;
  logic                    w_gate;
  logic                    w_unused_bits;

  logic                    r_s1_gate, r_s1_last;
  logic signed [VEC_W-1:0] r_s1_x, r_s1_y;
  logic [MAG_W-1:0]        r_s1_mag;

  logic                    r_s2_gate, r_s2_last;
  logic signed [WGT_W-1:0] w_wx, w_wy;

  logic [ACC_W-1:0]        r_acc_x, r_acc_y, r_res_x, r_res_y;
  logic [CNT_W-1:0]        r_acc_cnt, r_res_cnt;
  logic                    r_acc_ovf, r_res_ovf;
  sat_sum_t                w_sum_x, w_sum_y;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_ovf_next;

  assign w_unused_bits = ^vector_in[VEC_IN_W-1:2*VEC_W];
  assign w_idx_ext     = 32'(r_bin_idx);
  assign w_beat_last   = valid_in & last_in;
  assign w_gate        = valid_in
                       & (w_idx_ext >= $unsigned(BIN_LO))
                       & (w_idx_ext <= $unsigned(BIN_HI))
                       & (mag_in >= mag_threshold_in);

  // Bin index sticks at the top when a frame overruns without last_in.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_bin_idx <= '0;
    end else if (valid_in) begin
      if (last_in)                    r_bin_idx <= '0;
      else if (r_bin_idx != IDX_MAX)  r_bin_idx <= r_bin_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_s1_gate <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      r_s1_mag  <= '0;
      r_s2_gate <= 1'b0;
      r_s2_last <= 1'b0;
    end else begin
      r_s1_gate <= w_gate;
      r_s1_last <= w_beat_last;
      r_s1_x    <= vector_in[X_LSB +: VEC_W];
      r_s1_y    <= vector_in[Y_LSB +: VEC_W];
      r_s1_mag  <= mag_in;
      r_s2_gate <= r_s1_gate;
      r_s2_last <= r_s1_last;
    end
  end

  mag_weighter u_weight_x (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .i_comp     (r_s1_x),
    .i_mag      (r_s1_mag),
    .o_weighted (w_wx)
  );

  mag_weighter u_weight_y (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .i_comp     (r_s1_y),
    .i_mag      (r_s1_mag),
    .o_weighted (w_wy)
  );

  always_comb begin
    w_sum_x    = sat_add(r_acc_x, r_s2_gate ? w_wx : '0);
    w_sum_y    = sat_add(r_acc_y, r_s2_gate ? w_wy : '0);
    w_ovf_next = r_acc_ovf | w_sum_x.ovf | w_sum_y.ovf;
    // Count clamps rather than wraps on frames that overrun the index range.
    w_cnt_next = (r_s2_gate && (r_acc_cnt != {CNT_W{1'b1}})) ? r_acc_cnt + 1'b1 : r_acc_cnt;
  end

  // The last beat lands in the result registers and the accumulators restart
  // at zero, so the following frame's first beat is never merged or lost.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_acc_x   <= '0;
      r_acc_y   <= '0;
      r_acc_cnt <= '0;
      r_acc_ovf <= 1'b0;
      r_res_x   <= '0;
      r_res_y   <= '0;
      r_res_cnt <= '0;
      r_res_ovf <= 1'b0;
    end else if (r_s2_last) begin
      r_res_x   <= w_sum_x.sum;
      r_res_y   <= w_sum_y.sum;
      r_res_cnt <= w_cnt_next;
      r_res_ovf <= w_ovf_next;
      r_acc_x   <= '0;
      r_acc_y   <= '0;
      r_acc_cnt <= '0;
      r_acc_ovf <= 1'b0;
    end else begin
      r_acc_x   <= w_sum_x.sum;
      r_acc_y   <= w_sum_y.sum;
      r_acc_cnt <= w_cnt_next;
      r_acc_ovf <= w_ovf_next;
    end
  end

  // EMIT re-checks every pipeline stage for another in-flight last beat so
  // very short frames still get their own strobe.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state      <= ST_ACCUM;
      valid_out    <= 1'b0;
      x_out        <= '0;
      y_out        <= '0;
      count_out    <= '0;
      overflow_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (r_state)
        ST_ACCUM: if (w_beat_last) r_state <= ST_DRAIN;
        ST_DRAIN: if (r_s2_last)   r_state <= ST_EMIT;
        ST_EMIT: begin
          valid_out    <= 1'b1;
          x_out        <= r_res_x;
          y_out        <= r_res_y;
          count_out    <= r_res_cnt;
          overflow_out <= r_res_ovf;
          if (r_s2_last)                     r_state <= ST_EMIT;
          else if (w_beat_last || r_s1_last) r_state <= ST_DRAIN;
          else                               r_state <= ST_ACCUM;
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_direction_accumulator.sv
// Bench for direction_accumulator: two instances (narrow and full bin window)
// share stimulus and are scored against a per-beat arithmetic model.
module tb_direction_accumulator;

  localparam int     NB   = 1024;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [10:0] cnt;
    logic        ovf;
  } res_t;

  typedef struct {
    res_t r;
    int   cyc;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [37:0] vector_in;
  logic [15:0] mag_in, mag_threshold_in;
  logic        valid_in, last_in;

  logic [31:0] x0, y0, x1, y1;
  logic [10:0] c0, c1;
  logic        vo0, vo1, ov0, ov1;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     m_idx    = 0;
  longint mx[2], my[2];
  int     mc[2];
  bit     mo[2];
  exp_t   exp_q0[$], exp_q1[$];
  res_t   held[2];
  int     n_strobes[2];
  int     strobe_cyc[2];

  direction_accumulator #(.FRAME_BINS(NB), .BIN_LO(4), .BIN_HI(127)) u_dut0 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .vector_in(vector_in), .mag_in(mag_in),
    .valid_in(valid_in), .last_in(last_in), .mag_threshold_in(mag_threshold_in),
    .x_out(x0), .y_out(y0), .count_out(c0), .valid_out(vo0), .overflow_out(ov0)
  );

  direction_accumulator #(.FRAME_BINS(NB), .BIN_LO(4), .BIN_HI(1023)) u_dut1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .vector_in(vector_in), .mag_in(mag_in),
    .valid_in(valid_in), .last_in(last_in), .mag_threshold_in(mag_threshold_in),
    .x_out(x1), .y_out(y1), .count_out(c1), .valid_out(vo1), .overflow_out(ov1)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint weight(input logic [15:0] comp, input logic [15:0] mag);
    longint p;
    p = longint'($signed(comp)) * longint'(mag);
    return p >>> 13;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0; my[d] = 0; mc[d] = 0; mo[d] = 1'b0;
    end
  endtask

  // One accepted beat: window/threshold test, clamped sums, then frame close.
  task automatic model_accept(input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] mag, input logic [15:0] thr,
                              input bit last);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      int     hi;
      longint sx, sy;
      hi = (d == 0) ? 127 : 1023;
      if (m_idx >= 4 && m_idx <= hi && mag >= thr) begin
        sx = mx[d] + weight(x, mag);
        sy = my[d] + weight(y, mag);
        if (sx > MAXV) begin sx = MAXV; mo[d] = 1'b1; end
        if (sx < MINV) begin sx = MINV; mo[d] = 1'b1; end
        if (sy > MAXV) begin sy = MAXV; mo[d] = 1'b1; end
        if (sy < MINV) begin sy = MINV; mo[d] = 1'b1; end
        mx[d] = sx;
        my[d] = sy;
        if (mc[d] < 2047) mc[d]++;
      end
      if (last) begin
        e.r   = '{x: 32'(mx[d]), y: 32'(my[d]), cnt: 11'(mc[d]), ovf: mo[d]};
        e.cyc = cyc + 3;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
    end
    if (last) begin
      model_clear();
      m_idx = 0;
    end else if (m_idx != NB - 1) begin
      m_idx++;
    end
  endtask

  task automatic monitor(input int d, input logic vo, input res_t got);
    exp_t e;
    bit   have;
    if (vo) begin
      n_strobes[d]++;
      strobe_cyc[d] = cyc;
      have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      if (!have) begin
        check($sformatf("d%0d_spurious_strobe", d), 96'(vo), 96'(0));
      end else begin
        if (d == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        check($sformatf("d%0d_result", d), 96'(got), 96'(e.r));
        check($sformatf("d%0d_strobe_cycle", d), 96'(cyc), 96'(e.cyc));
        held[d] = e.r;
      end
    end else begin
      check($sformatf("d%0d_hold", d), 96'(got), 96'(held[d]));
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_n_in) begin
      monitor(0, vo0, '{x: x0, y: y0, cnt: c0, ovf: ov0});
      monitor(1, vo1, '{x: x1, y: y1, cnt: c1, ovf: ov1});
    end
  end

  task automatic beat(input bit v, input bit l, input logic [15:0] x,
                      input logic [15:0] y, input logic [15:0] mag);
    vector_in = {6'($urandom), y, x};
    mag_in    = mag;
    valid_in  = v;
    last_in   = l;
    @(posedge clk_in);
    #1;
    if (v) model_accept(x, y, mag, mag_threshold_in, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      beat(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic rand_frame(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(99)) < gap_pct) idle(1);
      beat(1'b1, i == n - 1, 16'($urandom), 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic do_reset(input int n);
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    last_in  = 1'b0;
    model_clear();
    m_idx = 0;
    exp_q0.delete();
    exp_q1.delete();
    held[0] = '0;
    held[1] = '0;
    repeat (n) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  initial begin
    int lc, s0, first_strobe;
    rst_n_in = 1'b0;
    vector_in = '0; mag_in = '0; valid_in = 1'b0; last_in = 1'b0; mag_threshold_in = '0;
    n_strobes[0] = 0; n_strobes[1] = 0;
    strobe_cyc[0] = 0; strobe_cyc[1] = 0;

    do_reset(3);
    check("rst_valid0", 96'(vo0), 96'(0));
    check("rst_x0",     96'(x0),  96'(0));
    check("rst_y0",     96'(y0),  96'(0));
    check("rst_cnt0",   96'(c0),  96'(0));
    check("rst_ovf0",   96'(ov0), 96'(0));
    check("rst_valid1", 96'(vo1), 96'(0));
    check("rst_x1",     96'(x1),  96'(0));
    check("rst_ovf1",   96'(ov1), 96'(0));

    // Unit vectors at full magnitude over bins 4-7.
    mag_threshold_in = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) beat(1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
      else       beat(1'b1, i == 7, 16'h0400, 16'hFC00, 16'h2000);
    end
    lc = cyc;
    idle(5);
    check("basic_x",     96'(x0),            96'(32'h0000_1000));
    check("basic_y",     96'(y0),            96'(32'hFFFF_F000));
    check("basic_cnt",   96'(c0),            96'(4));
    check("basic_ovf",   96'(ov0),           96'(0));
    check("basic_delay", 96'(strobe_cyc[0]), 96'(lc + 3));

    // Threshold rejects every other bin.
    mag_threshold_in = 16'h1000;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) beat(1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
      else       beat(1'b1, i == 11, 16'h0400, 16'($urandom), (i % 2 == 0) ? 16'h0800 : 16'h2000);
    end
    idle(5);
    check("thr_cnt", 96'(c0), 96'(4));
    check("thr_x",   96'(x0), 96'(32'h0000_1000));

    // Only out-of-window bins carry magnitude: empty frame still strobes.
    mag_threshold_in = 16'h0001;
    s0 = n_strobes[0];
    for (int i = 0; i <= 200; i++)
      beat(1'b1, i == 200, 16'h7FFF, 16'($urandom), (i < 4 || i >= 128) ? 16'hFFFF : 16'h0000);
    idle(5);
    check("empty_strobes", 96'(n_strobes[0] - s0), 96'(1));
    check("empty_cnt",     96'(c0),  96'(0));
    check("empty_x",       96'(x0),  96'(0));
    check("empty_y",       96'(y0),  96'(0));
    check("empty_ovf",     96'(ov0), 96'(0));

    // Back-to-back 128-bin frames.
    mag_threshold_in = 16'($urandom);
    rand_frame(128, 0);
    rand_frame(128, 0);
    first_strobe = strobe_cyc[0];
    idle(5);
    check("b2b_spacing", 96'(strobe_cyc[0] - first_strobe), 96'(128));

    // Random frames with gaps and random threshold.
    for (int f = 0; f < 6; f++) begin
      mag_threshold_in = 16'($urandom_range(16'h3000));
      rand_frame(int'($urandom_range(5, 300)), 20);
      idle(int'($urandom_range(0, 4)));
    end
    idle(5);

    // Reset mid-frame at bin 50 drops the partial frame.
    mag_threshold_in = 16'h0000;
    for (int i = 0; i < 50; i++)
      beat(1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
    s0 = n_strobes[0];
    do_reset(1);
    rand_frame(30, 0);
    idle(5);
    check("reset_strobes", 96'(n_strobes[0] - s0), 96'(1));

    // Overrunning frame saturates the full-window accumulators both ways.
    mag_threshold_in = 16'h0000;
    for (int i = 0; i < 8300; i++)
      beat(1'b1, i == 8299, 16'h7FFF, 16'h8000, 16'hFFFF);
    idle(5);
    check("sat_x",   96'(x1),  96'(32'h7FFF_FFFF));
    check("sat_y",   96'(y1),  96'(32'h8000_0000));
    check("sat_ovf", 96'(ov1), 96'(1));
    rand_frame(10, 0);
    idle(5);
    check("sat_ovf_cleared", 96'(ov1), 96'(0));

    idle(10);
    check("pending0", 96'(exp_q0.size()), 96'(0));
    check("pending1", 96'(exp_q1.size()), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
